unidade_controle_multiciclo: RTL
================================

# unidade_controle_multiciclo

Multicycle control unit for the RV32I subset (ADD, OR, SLL, ADDI, LH, SH, BNE). It sits between the instruction memory/decoder and the datapath (PC, IR, register file, ALU, data memory). It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives all datapath enables and selects. It waits on a data-memory ready handshake, traps on unsupported encodings, and counts retired instructions.

## Interface
- `LARGURA_CONTADOR`, 32: width of the retired-instruction counter.
- `clock  input  1`: single clock; all state updates on the rising edge.
- `reset  input  1`: asynchronous, active-high; clears state and all registered outputs.
- `inicio  input  1`: start request; sampled only in OCIOSO.
- `opcode  input  7`: decoded opcode of the current IR.
- `funct3  input  3`: decoded funct3.
- `funct7  input  7`: decoded funct7.
- `zero  input  1`: ALU zero flag, valid in EXECUTA.
- `mem_pronta  input  1`: data memory done/ready.
- `pc_escreve  output  1`: PC load enable.
- `pc_fonte  output  1`: 0 = PC+4, 1 = PC+branch offset.
- `ir_escreve  output  1`: IR/decoder latch enable.
- `reg_escreve  output  1`: register-file write enable.
- `mem_para_reg  output  1`: write-back source; 0 = ALU, 1 = memory.
- `alu_fonte_b  output  1`: ALU B source; 0 = rs2, 1 = immediate.
- `alu_op  output  2`: ALU operation; 00 = ADD, 01 = OR, 10 = SLL, 11 = SUB.
- `mem_le  output  1`: LH request.
- `mem_escreve  output  1`: SH request.
- `ocupado  output  1`: high in every state except OCIOSO and ERRO.
- `erro  output  1`: illegal-instruction trap flag.
- `instrucoes_concluidas  output  LARGURA_CONTADOR`: retired-instruction count.

## Operation
- States: OCIOSO, BUSCA, DECODIFICA, EXECUTA, MEMORIA, ESCRITA, ERRO. Encoding is binary (3 bits) and defined in the package.
- OCIOSO → BUSCA when `inicio` = 1; otherwise stay.
- BUSCA: `ir_escreve` = 1, `pc_escreve` = 1, `pc_fonte` = 0. Always → DECODIFICA.
- DECODIFICA: classify from the sampled opcode/funct3/funct7. Legal encodings:
  - R type (0110011): ADD 000/0000000, SLL 001/0000000, OR 110/0000000.
  - ADDI: 0010011/000.
  - LH: 0000011/001.
  - SH: 0100011/001.
  - BNE: 1100011/001.
  - Legal → EXECUTA. Anything else → ERRO.
- EXECUTA:
  - R type: `alu_fonte_b` = 0, `alu_op` from funct3 → ESCRITA.
  - ADDI: `alu_fonte_b` = 1, `alu_op` = ADD → ESCRITA.
  - LH/SH: `alu_fonte_b` = 1, `alu_op` = ADD (address) → MEMORIA.
  - BNE: `alu_op` = SUB. If `zero` = 0, assert `pc_escreve` with `pc_fonte` = 1. Retire and → BUSCA.
- MEMORIA: hold `mem_le` (LH) or `mem_escreve` (SH) until `mem_pronta` = 1 is sampled. Then LH → ESCRITA; SH retires → BUSCA.
- ESCRITA: `reg_escreve` = 1, `mem_para_reg` = 1 for LH and 0 otherwise. Retire → BUSCA.
- Retire: `instrucoes_concluidas` increments by 1 on the exit edge of the final state. It wraps modulo 2^`LARGURA_CONTADOR`.
- ERRO: sticky; `erro` = 1, all enables 0, counter frozen. Exit only via reset.
- Instruction class is latched into an internal register in DECODIFICA and used by all later states.

## Timing
- All control outputs are registered Moore decodes of the state plus the latched class. The exception is the BNE `pc_escreve` in EXECUTA, which is a combinational function of `zero` in that state.
- Reset: state = OCIOSO, all outputs 0, counter 0, latched class cleared.
- Cycles per instruction:
  - BNE: 3.
  - R type and ADDI: 4.
  - SH: 4 + wait cycles.
  - LH: 5 + wait cycles.
  - "Wait cycles" = cycles with `mem_pronta` = 0.
- `mem_pronta` already high on the first MEMORIA cycle gives zero wait cycles. `mem_pronta` seen outside MEMORIA is ignored.
- `inicio` held high is ignored after leaving OCIOSO. The unit never returns to OCIOSO except through reset.
- Reset mid-instruction (any state, including MEMORIA with a request pending) drops all requests asynchronously. No partial retire is counted.

## Structure
- Package `pacote_controle`:
  - State enum.
  - Opcode constants (OP_TIPO_R, OP_ADDI, OP_LH, OP_SH, OP_BNE).
  - funct3/funct7 constants.
  - `alu_op` encodings.
  - Instruction-class enum (R_ADD, R_OR, R_SLL, ADDI, LH, SH, BNE).
- One natural sub-module, `classificador_instrucao`: a combinational legality and class decoder from opcode/funct3/funct7 to {valida, classe}. The FSM and counter stay in the top.

## Test plan
- Reset, then `inicio` pulse, then ADD (0110011/000/0000000):
  - BUSCA shows `ir_escreve` = `pc_escreve` = 1; ESCRITA shows `reg_escreve` = 1 with `alu_op` = 00.
  - Counter = 1 after 4 cycles.
- LH with `mem_pronta` held low for 3 cycles:
  - `mem_le` = 1 for exactly 4 cycles.
  - ESCRITA shows `mem_para_reg` = 1.
  - 8 cycles total.
- BNE twice:
  - `zero` = 0: `pc_escreve` = 1 and `pc_fonte` = 1 in EXECUTA.
  - `zero` = 1: `pc_escreve` = 0.
  - Each takes 3 cycles; counter +2.
- SH with `mem_pronta` = 1 immediately:
  - `mem_escreve` = 1 for 1 cycle, `reg_escreve` never asserted.
  - Next state BUSCA; 4 cycles.
- Opcode 0110011 with funct7 = 0100000 (SUB, unsupported):
  - ERRO entered after DECODIFICA; `erro` = 1, `ocupado` = 0.
  - Counter frozen, all enables 0 until reset.
- Async reset asserted during MEMORIA of LH:
  - `mem_le` drops in the same cycle; state OCIOSO, counter 0.
  - Resume with `inicio` runs ADDI correctly.

Source files
------------

// File: rtl/unidade_controle_multiciclo_pkg.sv
// rtl/unidade_controle_multiciclo_pkg.sv - states, encodings and control word for the RV32I-subset control unit
package pacote_controle;

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    BUSCA      = 3'd1,
    DECODIFICA = 3'd2,
    EXECUTA    = 3'd3,
    MEMORIA    = 3'd4,
    ESCRITA    = 3'd5,
    ERRO       = 3'd6
  } estado_t;

  // R_ADD sits at zero so a cleared class register reads as a harmless value
  typedef enum logic [2:0] {
    R_ADD = 3'd0,
    R_OR  = 3'd1,
    R_SLL = 3'd2,
    ADDI  = 3'd3,
    LH    = 3'd4,
    SH    = 3'd5,
    BNE   = 3'd6
  } classe_t;

  localparam logic [6:0] OP_TIPO_R = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LH     = 7'b0000011;
  localparam logic [6:0] OP_SH     = 7'b0100011;
  localparam logic [6:0] OP_BNE    = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_SLL = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  typedef struct packed {
    logic       pc_escreve;
    logic       pc_fonte;
    logic       ir_escreve;
    logic       reg_escreve;
    logic       mem_para_reg;
    logic       alu_fonte_b;
    logic [1:0] alu_op;
    logic       mem_le;
    logic       mem_escreve;
    logic       ocupado;
    logic       erro;
  } sinais_t;

  function automatic logic [1:0] alu_op_tipo_r(input classe_t classe);
    logic [1:0] op;
    op = ALU_ADD;
    case (classe)
      R_OR:    op = ALU_OR;
      R_SLL:   op = ALU_SLL;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// rtl/unidade_controle_multiciclo_if.sv - decoder/datapath-facing signal bundle of the control unit
interface unidade_controle_multiciclo_if #(
  parameter int LARGURA_CONTADOR = 32
);

  logic                        inicio;
  logic [6:0]                  opcode;
  logic [2:0]                  funct3;
  logic [6:0]                  funct7;
  logic                        zero;
  logic                        mem_pronta;

  logic                        pc_escreve;
  logic                        pc_fonte;
  logic                        ir_escreve;
  logic                        reg_escreve;
  logic                        mem_para_reg;
  logic                        alu_fonte_b;
  logic [1:0]                  alu_op;
  logic                        mem_le;
  logic                        mem_escreve;
  logic                        ocupado;
  logic                        erro;
  logic [LARGURA_CONTADOR-1:0] instrucoes_concluidas;

  modport master (
    input  inicio, opcode, funct3, funct7, zero, mem_pronta,
    output pc_escreve, pc_fonte, ir_escreve, reg_escreve, mem_para_reg,
           alu_fonte_b, alu_op, mem_le, mem_escreve, ocupado, erro,
           instrucoes_concluidas
  );

  modport slave (
    output inicio, opcode, funct3, funct7, zero, mem_pronta,
    input  pc_escreve, pc_fonte, ir_escreve, reg_escreve, mem_para_reg,
           alu_fonte_b, alu_op, mem_le, mem_escreve, ocupado, erro,
           instrucoes_concluidas
  );

endinterface

// File: rtl/unidade_controle_multiciclo_classificador.sv
// rtl/unidade_controle_multiciclo_classificador.sv - combinational legality and class decoder
module classificador_instrucao
  import pacote_controle::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic       o_valida,
  output classe_t    o_classe
);

  always_comb begin
    o_valida = 1'b0;
    o_classe = R_ADD;
    case (i_opcode)
      OP_TIPO_R: begin
        if (i_funct7 == F7_BASE) begin
          case (i_funct3)
            F3_ADD: begin o_valida = 1'b1; o_classe = R_ADD; end
            F3_SLL: begin o_valida = 1'b1; o_classe = R_SLL; end
            F3_OR:  begin o_valida = 1'b1; o_classe = R_OR;  end
            default: o_valida = 1'b0;
          endcase
        end
      end
      OP_ADDI: if (i_funct3 == F3_ADDI) begin o_valida = 1'b1; o_classe = ADDI; end
      OP_LH:   if (i_funct3 == F3_LH)   begin o_valida = 1'b1; o_classe = LH;   end
      OP_SH:   if (i_funct3 == F3_SH)   begin o_valida = 1'b1; o_classe = SH;   end
      OP_BNE:  if (i_funct3 == F3_BNE)  begin o_valida = 1'b1; o_classe = BNE;  end
      default: o_valida = 1'b0;
    endcase
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// rtl/unidade_controle_multiciclo.sv - multicycle FSM, registered control word and retire counter
module unidade_controle_multiciclo
  import pacote_controle::*;
#(
  parameter int LARGURA_CONTADOR = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  unidade_controle_multiciclo_if.master bus
);

  localparam logic [LARGURA_CONTADOR-1:0] W_UM = {{(LARGURA_CONTADOR-1){1'b0}}, 1'b1};

  estado_t                     r_estado;
  estado_t                     w_proximo;
  classe_t                     r_classe;
  classe_t                     w_classe_prox;
  classe_t                     w_classe_dec;
  logic                        w_valida;
  sinais_t                     r_sinais;
  sinais_t                     w_sinais;
  logic                        w_retira;
  logic                        w_desvio_bne;
  logic [LARGURA_CONTADOR-1:0] r_contador;

  classificador_instrucao u_classificador (
    .i_opcode (bus.opcode),
    .i_funct3 (bus.funct3),
    .i_funct7 (bus.funct7),
    .o_valida (w_valida),
    .o_classe (w_classe_dec)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado   <= OCIOSO;
      r_classe   <= R_ADD;
      r_sinais   <= '0;
      r_contador <= '0;
    end else begin
      r_estado <= w_proximo;
      r_classe <= w_classe_prox;
      r_sinais <= w_sinais;
      if (w_retira) begin
        r_contador <= r_contador + W_UM;
      end
    end
  end

  // Outputs are decoded from the state being entered, so the register holds them during that state
  always_comb begin
    w_proximo     = r_estado;
    w_retira      = 1'b0;
    w_classe_prox = (r_estado == DECODIFICA) ? w_classe_dec : r_classe;
    w_sinais      = '0;

    case (r_estado)
      OCIOSO:     if (bus.inicio) w_proximo = BUSCA;
      BUSCA:      w_proximo = DECODIFICA;
      DECODIFICA: w_proximo = w_valida ? EXECUTA : ERRO;
      EXECUTA: begin
        case (r_classe)
          BNE: begin
            w_proximo = BUSCA;
            w_retira  = 1'b1;
          end
          LH, SH:  w_proximo = MEMORIA;
          default: w_proximo = ESCRITA;
        endcase
      end
      MEMORIA: begin
        if (bus.mem_pronta) begin
          if (r_classe == SH) begin
            w_proximo = BUSCA;
            w_retira  = 1'b1;
          end else begin
            w_proximo = ESCRITA;
          end
        end
      end
      ESCRITA: begin
        w_proximo = BUSCA;
        w_retira  = 1'b1;
      end
      ERRO:    w_proximo = ERRO;
      default: w_proximo = ERRO;
    endcase

    case (w_proximo)
      BUSCA: begin
        w_sinais.ir_escreve = 1'b1;
        w_sinais.pc_escreve = 1'b1;
        w_sinais.ocupado    = 1'b1;
      end
      DECODIFICA: w_sinais.ocupado = 1'b1;
      EXECUTA: begin
        w_sinais.ocupado = 1'b1;
        case (w_classe_prox)
          R_ADD, R_OR, R_SLL: begin
            w_sinais.alu_fonte_b = 1'b0;
            w_sinais.alu_op      = alu_op_tipo_r(w_classe_prox);
          end
          ADDI, LH, SH: begin
            w_sinais.alu_fonte_b = 1'b1;
            w_sinais.alu_op      = ALU_ADD;
          end
          BNE: begin
            w_sinais.alu_op   = ALU_SUB;
            w_sinais.pc_fonte = 1'b1;
          end
          default: w_sinais.alu_op = ALU_ADD;
        endcase
      end
      MEMORIA: begin
        w_sinais.ocupado     = 1'b1;
        w_sinais.mem_le      = (w_classe_prox == LH);
        w_sinais.mem_escreve = (w_classe_prox == SH);
      end
      ESCRITA: begin
        w_sinais.ocupado      = 1'b1;
        w_sinais.reg_escreve  = 1'b1;
        w_sinais.mem_para_reg = (w_classe_prox == LH);
      end
      ERRO:    w_sinais.erro = 1'b1;
      default: w_sinais = '0;
    endcase
  end

  // The taken-branch PC load cannot be registered: zero is only valid during EXECUTA itself
  assign w_desvio_bne = (r_estado == EXECUTA) && (r_classe == BNE) && !bus.zero;

  assign bus.pc_escreve            = r_sinais.pc_escreve | w_desvio_bne;
  assign bus.pc_fonte              = r_sinais.pc_fonte;
  assign bus.ir_escreve            = r_sinais.ir_escreve;
  assign bus.reg_escreve           = r_sinais.reg_escreve;
  assign bus.mem_para_reg          = r_sinais.mem_para_reg;
  assign bus.alu_fonte_b           = r_sinais.alu_fonte_b;
  assign bus.alu_op                = r_sinais.alu_op;
  assign bus.mem_le                = r_sinais.mem_le;
  assign bus.mem_escreve           = r_sinais.mem_escreve;
  assign bus.ocupado               = r_sinais.ocupado;
  assign bus.erro                  = r_sinais.erro;
  assign bus.instrucoes_concluidas = r_contador;

endmodule
